unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-port instruction/data memory between the fetch stage (instruction reads) and the memory-access stage (loads/stores) of the 5-stage RISC-V pipeline.
- Sequences each access over a req/ack memory bus with variable latency.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Drives stall signals the pipeline uses to freeze the PC and pipeline registers until its access completes.

Parameters:
- ADDR_W, 32, address width of requesters and bus.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, cycles in a bus state without bus_ack before the access is aborted; legal range 2..255.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request, level; held until if_ready.
- if_addr  in  ADDR_W  fetch address, stable while if_req is high.
- if_rdata  out  DATA_W  fetched instruction, valid while if_ready is high.
- if_ready  out  1  one-cycle completion pulse for fetch.
- stall_if  out  1  if_req && !if_ready; combinational.
- dm_req  in  1  data access request, level; held until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_be  in  4  byte enables for stores.
- dm_rdata  out  DATA_W  load data, valid while dm_ready is high.
- dm_ready  out  1  one-cycle completion pulse for data access.
- stall_dm  out  1  dm_req && !dm_ready; combinational.
- bus_req  out  1  memory request, registered.
- bus_we  out  1  registered.
- bus_addr  out  ADDR_W  registered.
- bus_wdata  out  DATA_W  registered.
- bus_be  out  4  registered; forced to 4'hF for fetches.
- bus_ack  in  1  one-cycle completion from memory.
- bus_rdata  in  DATA_W  valid with bus_ack.
- bus_timeout  out  1  sticky abort flag, cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all registered outputs cleared (bus_*, if_ready, dm_ready, bus_timeout = 0; if_rdata, dm_rdata = 0).
  - Timeout counter and last_grant cleared.
  - An in-flight bus access is abandoned mid-operation; the memory tolerates a dropped bus_req.
- States: IDLE, BUS_IF, BUS_DM, RESP.
- IDLE:
  - Samples the requests at the clock edge.
  - dm_req has fixed priority over if_req: it is the older instruction, and this avoids deadlock when the load stalls fetch.
  - Winner's address, data and we are latched into the bus_* registers; bus_req=1 from the next cycle.
  - Next state is BUS_DM or BUS_IF. No request: stay in IDLE.
- BUS_IF / BUS_DM:
  - bus_req is held; the counter increments each cycle.
  - On bus_ack: bus_req=0; bus_rdata is captured into if_rdata (fetch) or dm_rdata (loads only; dm_rdata holds its old value for stores). Go to RESP.
  - On counter == TIMEOUT_CYCLES-1 with no ack: abort. bus_req=0, bus_timeout=1, captured rdata = 0. Go to RESP.
  - bus_ack in the same cycle as the timeout: ack wins, no timeout flagged.
- RESP:
  - The matching if_ready or dm_ready is 1 for exactly one cycle.
  - The requester advances on this edge, so it deasserts or changes its request. Then IDLE.
  - RESP prevents double service of a held request; cost is one bubble cycle per access.
- Latency: request seen in IDLE at edge N; bus_req from N+1; ack at cycle M; ready at M+1; next arbitration at M+2.
- bus_ack while in IDLE or RESP is ignored.
- Request inputs changing mid-access do not affect the latched bus_* registers.
- Counter is reset on every entry to BUS_IF or BUS_DM.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, the requester not served last (last_grant register) wins. last_grant is updated on each grant.
- Undefined: fixed dm priority; no last_grant register.

Decomposition:
- Shared package riscv_pkg holds:
  - arb_state_t enum (IDLE, BUS_IF, BUS_DM, RESP).
  - grant_t enum (GNT_IF, GNT_DM).
  - ADDR_W and DATA_W defaults.
  - The BE_FULL = 4'hF constant.
- One natural sub-module, arb_timeout_counter: clear/enable inputs, expired output; width derived from TIMEOUT_CYCLES.

Test Plan:
- Fetch-only read: if_req=1, if_addr=0x10; bus_ack at 3rd bus cycle with bus_rdata=0xDEADBEEF. Expect bus_addr=0x10, bus_be=4'hF, if_ready one cycle later with if_rdata=0xDEADBEEF, and stall_if high until that cycle.
- Simultaneous requests: if_req and dm_req (load 0x200) raised on the same cycle, ack latency 1. Expect the dm access first with dm_ready, then the if access. With ARB_ROUND_ROBIN_EN and 4 back-to-back dual requests, grants alternate dm,if,dm,if.
- Store: dm_we=1, dm_addr=0x204, dm_wdata=0x12345678, dm_be=4'b0011. Expect bus_we=1, bus_be=4'b0011, dm_ready pulse, and dm_rdata unchanged from its prior value.
- Timeout: TIMEOUT_CYCLES=8, bus_ack never asserted. Expect bus_req to fall after 8 bus cycles, a dm_ready pulse with dm_rdata=0, and bus_timeout=1 held until reset. Ack on the 8th cycle: no timeout.
- Reset mid-access: reset=0 asynchronously while in BUS_DM. Expect bus_req=0 immediately with no clock edge needed, and no ready pulse. After release, a fresh if_req is served normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the pipeline's unified memory arbiter.
// Consumers: unified_mem_arbiter and arb_timeout_counter.
package riscv_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Byte-enable pattern for full-word accesses (always used by fetches).
    localparam logic [3:0] BE_FULL = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS_IF = 2'd1,
        BUS_DM = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // GNT_IF encodes as 0, so a cleared last-grant register favours dm first.
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts the cycles spent waiting for bus_ack and flags expiry on the last allowed cycle.
// Width is derived from TIMEOUT_CYCLES (legal range 2..255).
module arb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at LAST_CNT so a stuck enable never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and data-access requests onto one single-port req/ack memory bus.
// Define ARB_ROUND_ROBIN_EN for alternating grants on simultaneous requests; default is fixed dm priority.
module unified_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              stall_if,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_be,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_dm,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_timeout
);

    arb_state_t        state_q,       state_d;
    logic              bus_req_q,     bus_req_d;
    logic              bus_we_q,      bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q,    bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q,   bus_wdata_d;
    logic [3:0]        bus_be_q,      bus_be_d;
    logic [DATA_W-1:0] if_rdata_q,    if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,    dm_rdata_d;
    logic              if_ready_q,    if_ready_d;
    logic              dm_ready_q,    dm_ready_d;
    logic              bus_timeout_q, bus_timeout_d;
`ifdef ARB_ROUND_ROBIN_EN
    grant_t            last_grant_q,  last_grant_d;
`endif

    logic              bus_busy;
    logic              tmo_expired;
    logic              grant_any;
    grant_t            grant_sel;
    logic [DATA_W-1:0] capture_data;

    assign bus_busy = (state_q == BUS_IF) || (state_q == BUS_DM);

    arb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (!bus_busy),
        .enable_i  (bus_busy),
        .expired_o (tmo_expired)
    );

    // dm is the older instruction; letting it win avoids deadlock when a load stalls fetch.
    always_comb begin
        grant_any = if_req || dm_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_req && dm_req) begin
            grant_sel = (last_grant_q == GNT_DM) ? GNT_IF : GNT_DM;
        end else begin
            grant_sel = dm_req ? GNT_DM : GNT_IF;
        end
`else
        grant_sel = dm_req ? GNT_DM : GNT_IF;
`endif
    end

    // An ack beats a simultaneous timeout; an aborted access returns zero data.
    assign capture_data = bus_ack ? bus_rdata : '0;

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_be_d      = bus_be_q;
        if_rdata_d    = if_rdata_q;
        dm_rdata_d    = dm_rdata_q;
        if_ready_d    = 1'b0;
        dm_ready_d    = 1'b0;
        bus_timeout_d = bus_timeout_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d  = last_grant_q;
`endif

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    bus_req_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_sel;
`endif
                    if (grant_sel == GNT_DM) begin
                        bus_we_d    = dm_we;
                        bus_addr_d  = dm_addr;
                        bus_wdata_d = dm_wdata;
                        bus_be_d    = dm_be;
                        state_d     = BUS_DM;
                    end else begin
                        bus_we_d    = 1'b0;
                        bus_addr_d  = if_addr;
                        bus_wdata_d = '0;
                        bus_be_d    = BE_FULL;
                        state_d     = BUS_IF;
                    end
                end
            end

            BUS_IF, BUS_DM: begin
                if (bus_ack || tmo_expired) begin
                    bus_req_d = 1'b0;
                    state_d   = RESP;
                    if (!bus_ack) begin
                        bus_timeout_d = 1'b1;
                    end
                    if (state_q == BUS_IF) begin
                        if_rdata_d = capture_data;
                        if_ready_d = 1'b1;
                    end else begin
                        if (!bus_we_q) begin
                            dm_rdata_d = capture_data;
                        end
                        dm_ready_d = 1'b1;
                    end
                end
            end

            // One bubble so a request still held at the ready pulse is not served twice.
            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_be_q      <= 4'h0;
            if_rdata_q    <= '0;
            dm_rdata_q    <= '0;
            if_ready_q    <= 1'b0;
            dm_ready_q    <= 1'b0;
            bus_timeout_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q  <= GNT_IF;
`endif
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_be_q      <= bus_be_d;
            if_rdata_q    <= if_rdata_d;
            dm_rdata_q    <= dm_rdata_d;
            if_ready_q    <= if_ready_d;
            dm_ready_q    <= dm_ready_d;
            bus_timeout_q <= bus_timeout_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_be      = bus_be_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign if_ready    = if_ready_q;
    assign dm_ready    = dm_ready_q;
    assign bus_timeout = bus_timeout_q;

    assign stall_if = if_req && !if_ready_q;
    assign stall_dm = dm_req && !dm_ready_q;

endmodule
